// File: rtl/spea_pkg.sv
// spea_pkg: shared types and helpers for the segment parser
package spea_pkg;
  typedef enum logic [1:0] {IDLE, SCAN, EMIT, FIN} state_t;
  // A limit of zero or above the maximum means "as many as the hardware allows".
  function automatic int eff_limit(input int lim, input int max_seg);
    return (lim == 0 || lim > max_seg) ? max_seg : lim;
  endfunction
endpackage

// File: rtl/spea_seg_parser.sv
// spea_seg_parser: cuts a latched word into delimiter-terminated segments, LSB first
// Ports: clk/rst (async, active-high); en starts a run in IDLE;
// input_B/input_S data word and delimiter mask; seg_limit segments per run;
// out_seg/out_len/out_idx/out_ovf with out_valid/out_ready handshake;
// busy outside IDLE; done pulses at end of run with seg_total.
module spea_seg_parser
  import spea_pkg::*;
#(
  parameter int IN_W = 64,
  parameter int SEG_W = 32,
  parameter int MAX_SEG = 4,
  localparam int POS_W = $clog2(IN_W + 1),
  localparam int LEN_W = $clog2(SEG_W + 1),
  localparam int CNT_W = $clog2(MAX_SEG + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [IN_W-1:0]  input_B,
  input  logic [IN_W-1:0]  input_S,
  input  logic [CNT_W-1:0] seg_limit,
  output logic [SEG_W-1:0] out_seg,
  output logic [LEN_W-1:0] out_len,
  output logic [CNT_W-1:0] out_idx,
  output logic             out_ovf,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] seg_total
);
  state_t state_q, state_d;
  logic [IN_W-1:0] b_q, b_d, s_q, s_d, b_sh, s_sh;
  logic [POS_W-1:0] pos_q, pos_d;
  logic [LEN_W-1:0] len_q, len_d, olen_q, olen_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, lim_q, lim_d, total_q, total_d, oidx_q, oidx_d;
  logic [SEG_W-1:0] seg_q, seg_d, oseg_q, oseg_d;
  logic ovf_q, ovf_d, oovf_q, oovf_d, ovalid_q, ovalid_d;
  // The current bit sits at position 0 after shifting by pos.
  assign b_sh = b_q >> pos_q;
  assign s_sh = s_q >> pos_q;
  always_comb begin
    state_d = state_q;
    b_d = b_q;
    s_d = s_q;
    pos_d = pos_q;
    len_d = len_q;
    cnt_d = cnt_q;
    lim_d = lim_q;
    total_d = total_q;
    seg_d = seg_q;
    ovf_d = ovf_q;
    oseg_d = oseg_q;
    olen_d = olen_q;
    oidx_d = oidx_q;
    oovf_d = oovf_q;
    ovalid_d = ovalid_q;
    case (state_q)
      IDLE: if (en) begin
        b_d = input_B;
        s_d = input_S;
        lim_d = CNT_W'(eff_limit(int'(seg_limit), MAX_SEG));
        pos_d = '0;
        len_d = '0;
        cnt_d = '0;
        seg_d = '0;
        ovf_d = 1'b0;
        state_d = SCAN;
      end
      SCAN: begin
        if (len_q < LEN_W'(SEG_W)) begin
          seg_d = seg_q | (SEG_W'(b_sh[0]) << len_q);
          len_d = len_q + LEN_W'(1);
        end else ovf_d = 1'b1;
        pos_d = pos_q + POS_W'(1);
        state_d = (s_sh[0] || pos_q == POS_W'(IN_W - 1)) ? EMIT : SCAN;
      end
      EMIT: if (!ovalid_q) begin
        // First EMIT cycle captures the segment into the output holding registers.
        oseg_d = seg_q;
        olen_d = len_q;
        oidx_d = cnt_q;
        oovf_d = ovf_q;
        ovalid_d = 1'b1;
      end else if (out_ready) begin
        ovalid_d = 1'b0;
        cnt_d = cnt_q + CNT_W'(1);
        seg_d = '0;
        len_d = '0;
        ovf_d = 1'b0;
        state_d = (cnt_d == lim_q || pos_q == POS_W'(IN_W)) ? FIN : SCAN;
        total_d = (state_d == FIN) ? cnt_d : total_q;
      end
      FIN: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      b_q <= '0;
      s_q <= '0;
      pos_q <= '0;
      len_q <= '0;
      cnt_q <= '0;
      lim_q <= '0;
      total_q <= '0;
      seg_q <= '0;
      ovf_q <= 1'b0;
      oseg_q <= '0;
      olen_q <= '0;
      oidx_q <= '0;
      oovf_q <= 1'b0;
      ovalid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      b_q <= b_d;
      s_q <= s_d;
      pos_q <= pos_d;
      len_q <= len_d;
      cnt_q <= cnt_d;
      lim_q <= lim_d;
      total_q <= total_d;
      seg_q <= seg_d;
      ovf_q <= ovf_d;
      oseg_q <= oseg_d;
      olen_q <= olen_d;
      oidx_q <= oidx_d;
      oovf_q <= oovf_d;
      ovalid_q <= ovalid_d;
    end
  end
  assign out_seg = oseg_q;
  assign out_len = olen_q;
  assign out_idx = oidx_q;
  assign out_ovf = oovf_q;
  assign out_valid = ovalid_q;
  assign busy = state_q != IDLE;
  assign done = state_q == FIN;
  assign seg_total = total_q;
endmodule

// File: tb/tb_spea_seg_parser.sv
// tb_spea_seg_parser: randomized and directed checks of spea_seg_parser against a segment-list model
module tb_spea_seg_parser;
  logic clk = 1'b0;
  logic rst, en, out_ready;
  logic [63:0] input_B, input_S;
  logic [2:0] seg_limit;
  logic [31:0] out_seg;
  logic [5:0] out_len;
  logic [2:0] out_idx, seg_total;
  logic out_ovf, out_valid, busy, done;
  int n_vec = 0;
  int n_err = 0;
  logic [31:0] q_seg[$];
  int q_len[$];
  int q_raw[$];
  bit q_ovf[$];

  spea_seg_parser dut (
    .clk(clk), .rst(rst), .en(en), .input_B(input_B), .input_S(input_S),
    .seg_limit(seg_limit), .out_seg(out_seg), .out_len(out_len), .out_idx(out_idx),
    .out_ovf(out_ovf), .out_valid(out_valid), .out_ready(out_ready), .busy(busy),
    .done(done), .seg_total(seg_total)
  );

  always #5 clk = ~clk;

  task automatic build_model(input logic [63:0] b, input logic [63:0] s, input int lim);
    int lim_e, len, raw;
    logic [31:0] seg;
    q_seg.delete(); q_len.delete(); q_raw.delete(); q_ovf.delete();
    lim_e = (lim == 0 || lim > 4) ? 4 : lim;
    seg = '0; len = 0; raw = 0;
    for (int p = 0; p < 64; p++) begin
      raw++;
      if (len < 32) begin
        seg[len] = b[p];
        len++;
      end
      if (s[p] || p == 63) begin
        q_seg.push_back(seg); q_len.push_back(len); q_raw.push_back(raw); q_ovf.push_back(raw > 32);
        seg = '0; len = 0; raw = 0;
        if (q_seg.size() == lim_e) break;
      end
    end
  endtask

  task automatic run_scenario(input string name, input logic [63:0] b, input logic [63:0] s,
                              input logic [2:0] lim, input int ready_pct, input bit poke_en);
    int j, got, exp_j;
    bit fin, hold;
    logic [31:0] h_seg;
    logic [5:0] h_len;
    logic [2:0] h_idx;
    logic h_ovf;
    build_model(b, s, int'(lim));
    @(negedge clk);
    input_B = b; input_S = s; seg_limit = lim; en = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    en = 1'b0;
    j = 1; got = 0; fin = 0; hold = 0;
    exp_j = q_raw[0] + 2;
    h_seg = '0; h_len = '0; h_idx = '0; h_ovf = 1'b0;
    while (!fin && j < 3000) begin
      input_B = {$urandom, $urandom};
      input_S = {$urandom, $urandom};
      seg_limit = 3'($urandom_range(0, 7));
      en = poke_en ? 1'($urandom_range(0, 1)) : 1'b0;
      if (hold) begin
        n_vec++;
        if (out_valid !== 1'b1 || out_seg !== h_seg || out_len !== h_len || out_idx !== h_idx || out_ovf !== h_ovf) begin
          n_err++;
          $display("FAIL %s hold: valid=%b seg=%h len=%0d idx=%0d ovf=%b, required valid=1 seg=%h len=%0d idx=%0d ovf=%b",
                   name, out_valid, out_seg, out_len, out_idx, out_ovf, h_seg, h_len, h_idx, h_ovf);
        end
      end
      if (done) begin
        fin = 1;
        n_vec++;
        if (out_valid !== 1'b0 || seg_total !== 3'(q_seg.size()) || got != q_seg.size()) begin
          n_err++;
          $display("FAIL %s done: valid=%b seg_total=%0d accepted=%0d, required valid=0 total=%0d",
                   name, out_valid, seg_total, got, q_seg.size());
        end
      end else begin
        out_ready = ($urandom_range(1, 100) <= ready_pct);
        if (out_valid && !hold) begin
          n_vec++;
          if (got >= q_seg.size()) begin
            n_err++;
            $display("FAIL %s extra segment idx=%0d, required only %0d segments", name, out_idx, q_seg.size());
          end else if (out_seg !== q_seg[got] || out_len !== 6'(q_len[got]) || out_idx !== 3'(got) || out_ovf !== q_ovf[got]) begin
            n_err++;
            $display("FAIL %s seg%0d: seg=%h len=%0d idx=%0d ovf=%b, required seg=%h len=%0d idx=%0d ovf=%b",
                     name, got, out_seg, out_len, out_idx, out_ovf, q_seg[got], q_len[got], got, q_ovf[got]);
          end
          if (ready_pct == 100) begin
            n_vec++;
            if (j != exp_j) begin
              n_err++;
              $display("FAIL %s seg%0d latency: valid at cycle %0d, required %0d", name, got, j, exp_j);
            end
          end
        end
        hold = out_valid && !out_ready;
        if (out_valid) begin
          h_seg = out_seg; h_len = out_len; h_idx = out_idx; h_ovf = out_ovf;
        end
        if (out_valid && out_ready) begin
          got++;
          if (got < q_seg.size()) exp_j = j + q_raw[got] + 2;
        end
      end
      @(negedge clk);
      j++;
    end
    en = 1'b0;
    out_ready = 1'b0;
    n_vec++;
    if (!fin) begin
      n_err++;
      $display("FAIL %s timeout: no done within %0d cycles, required done", name, j);
    end else if (done !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL %s after done: done=%b busy=%b valid=%b, required all 0", name, done, busy, out_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; out_ready = 1'b0; input_B = '0; input_S = '0; seg_limit = '0;
    repeat (2) @(negedge clk);
    n_vec++;
    if ({out_seg, out_len, out_idx, out_ovf, out_valid, busy, done, seg_total} !== '0) begin
      n_err++;
      $display("FAIL reset: seg=%h len=%0d idx=%0d ovf=%b valid=%b busy=%b done=%b total=%0d, required all 0",
               out_seg, out_len, out_idx, out_ovf, out_valid, busy, done, seg_total);
    end
    rst = 1'b0;
  endtask

  task automatic test_directed();
    run_scenario("basic", 64'hA5, 64'h88, 3'd2, 100, 0);
    run_scenario("overflow", 64'hFFFF_0000_1234_5678, 64'h0, 3'd1, 100, 0);
    run_scenario("exhaust", {$urandom, $urandom}, 64'h8000_0000_0000_0001, 3'd0, 100, 0);
    run_scenario("adjacent", {$urandom, $urandom}, 64'h3, 3'd3, 100, 0);
    run_scenario("limit_over", {$urandom, $urandom}, 64'h0101_0101_0101_0101, 3'd7, 100, 0);
  endtask

  task automatic test_backpressure();
    run_scenario("backpressure", 64'hA5, 64'h88, 3'd2, 20, 1);
    run_scenario("bp_exhaust", {$urandom, $urandom}, 64'h8000_0000_0000_0001, 3'd4, 40, 1);
  endtask

  task automatic test_random();
    logic [63:0] b, s;
    for (int i = 0; i < 24; i++) begin
      b = {$urandom, $urandom};
      s = (i % 5 == 0) ? 64'h0 : ({$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom});
      run_scenario("random", b, s, 3'($urandom_range(0, 7)), (i % 2) ? 100 : 60, i[0]);
    end
  endtask

  task automatic test_async_reset();
    bit bad;
    @(negedge clk);
    input_B = {$urandom, $urandom}; input_S = 64'h0; seg_limit = 3'd1; en = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    en = 1'b0;
    repeat (10) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_vec++;
    if ({out_seg, out_len, out_idx, out_ovf, out_valid, busy, done, seg_total} !== '0) begin
      n_err++;
      $display("FAIL async_reset: seg=%h len=%0d valid=%b busy=%b done=%b total=%0d, required all 0",
               out_seg, out_len, out_valid, busy, done, seg_total);
    end
    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    repeat (80) begin
      @(negedge clk);
      if (out_valid || done || busy) bad = 1;
    end
    n_vec++;
    if (bad) begin
      n_err++;
      $display("FAIL async_reset residue: activity after reset, required idle");
    end
    run_scenario("after_reset", 64'hA5, 64'h88, 3'd2, 100, 0);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_random();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
